// File: rtl/mc_ctrl_fsm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_ctrl_fsm_pkg : state encodings, opcodes, mux select codes, control word
// Rev 1.0
// ---------------------------------------------------------------------------
package mc_ctrl_fsm_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXE  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_addi  = 6'b001000;

  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

  localparam logic [1:0] c_srcb_rt      = 2'b00;
  localparam logic [1:0] c_srcb_four    = 2'b01;
  localparam logic [1:0] c_srcb_sext    = 2'b10;
  localparam logic [1:0] c_srcb_sext_sh = 2'b11;

  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  // pc_we/pc_br are combined with mem_ready and zero at the top level
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic       pc_br;
    logic       ready_gate;
    logic [1:0] pc_src;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem2reg;
    logic       reg_we;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == c_op_rtype) || (op == c_op_lw) || (op == c_op_sw) ||
           (op == c_op_beq)   || (op == c_op_j)  || (op == c_op_addi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_fsm_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_ctrl_fsm_if : control-unit <-> datapath/memory signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface mc_ctrl_fsm_if #(
  parameter int OPW = 6,
  parameter int STW = 4
);
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;
  logic           mem_req;
  logic           mem_we;
  logic           iord;
  logic           ir_we;
  logic           pc_en;
  logic [1:0]     pc_src;
  logic           alu_srca;
  logic [1:0]     alu_srcb;
  logic [1:0]     alu_op;
  logic           reg_dst;
  logic           mem2reg;
  logic           reg_we;
  logic           illegal;
  logic [STW-1:0] state_o;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_en, pc_src, alu_srca, alu_srcb,
           alu_op, reg_dst, mem2reg, reg_we, illegal, state_o
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_en, pc_src, alu_srca, alu_srcb,
           alu_op, reg_dst, mem2reg, reg_we, illegal, state_o
  );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_fsm_out_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_ctrl_fsm_out_decode : state -> control word (pure combinational)
// Rev 1.0
// ---------------------------------------------------------------------------
module mc_ctrl_fsm_out_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_cw
);

  always_comb begin
    o_cw = '0;
    case (i_state)
      S_FETCH: begin
        o_cw.mem_req    = 1'b1;
        o_cw.ir_we      = 1'b1;
        o_cw.pc_we      = 1'b1;
        o_cw.ready_gate = 1'b1;
        o_cw.alu_srcb   = c_srcb_four;
        o_cw.alu_op     = c_aluop_add;
        o_cw.pc_src     = c_pcsrc_alu;
      end
      S_DECODE: begin
        o_cw.alu_srcb = c_srcb_sext_sh;
        o_cw.alu_op   = c_aluop_add;
      end
      S_MEMADR, S_ADDIEX: begin
        o_cw.alu_srca = 1'b1;
        o_cw.alu_srcb = c_srcb_sext;
        o_cw.alu_op   = c_aluop_add;
      end
      S_MEMRD: begin
        o_cw.mem_req = 1'b1;
        o_cw.iord    = 1'b1;
      end
      S_MEMWB: begin
        o_cw.reg_we  = 1'b1;
        o_cw.mem2reg = 1'b1;
      end
      S_MEMWR: begin
        o_cw.mem_req = 1'b1;
        o_cw.mem_we  = 1'b1;
        o_cw.iord    = 1'b1;
      end
      S_RTEXE: begin
        o_cw.alu_srca = 1'b1;
        o_cw.alu_srcb = c_srcb_rt;
        o_cw.alu_op   = c_aluop_funct;
      end
      S_ALUWB: begin
        o_cw.reg_we  = 1'b1;
        o_cw.reg_dst = 1'b1;
      end
      S_BEQ: begin
        o_cw.alu_srca = 1'b1;
        o_cw.alu_srcb = c_srcb_rt;
        o_cw.alu_op   = c_aluop_sub;
        o_cw.pc_src   = c_pcsrc_aluout;
        o_cw.pc_br    = 1'b1;
      end
      S_JUMP: begin
        o_cw.pc_src = c_pcsrc_jump;
        o_cw.pc_we  = 1'b1;
      end
      S_ADDIWB: begin
        o_cw.reg_we = 1'b1;
      end
      default: o_cw = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_ctrl_fsm : multi-cycle MIPS control unit (Moore FSM, req/ready memory)
// Rev 1.0
// ---------------------------------------------------------------------------
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  wire logic      clk,
  input  wire logic      rstn,
  mc_ctrl_fsm_if.master  bus
);

  state_t         r_state;
  state_t         w_next;
  logic           w_illegal;
  logic [OPW-1:0] w_op;
  ctrl_t          w_cw;

  assign w_op = bus.opcode;

  // Async reset: mem_req/mem_we drop as soon as rstn falls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_RST;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    case (r_state)
      S_RST:   w_next = S_FETCH;
      S_FETCH: if (bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (w_op == c_op_lw || w_op == c_op_sw) w_next = S_MEMADR;
        else if (w_op == c_op_rtype)            w_next = S_RTEXE;
        else if (w_op == c_op_beq)              w_next = S_BEQ;
        else if (w_op == c_op_j)                w_next = S_JUMP;
        else if (w_op == c_op_addi)             w_next = S_ADDIEX;
        else                                    w_next = S_FETCH;
        w_illegal = !is_known_op(w_op);
      end
      S_MEMADR: begin
        if (w_op == c_op_lw)      w_next = S_MEMRD;
        else if (w_op == c_op_sw) w_next = S_MEMWR;
        else                      w_next = S_FETCH;
      end
      S_MEMRD:  if (bus.mem_ready) w_next = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) w_next = S_FETCH;
      S_MEMWB:  w_next = S_FETCH;
      S_RTEXE:  w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BEQ:    w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  mc_ctrl_fsm_out_decode u_out_decode (
    .i_state (r_state),
    .o_cw    (w_cw)
  );

  // FETCH enables only fire on the cycle memory actually returns the word
  assign bus.ir_we    = w_cw.ir_we & bus.mem_ready;
  assign bus.pc_en    = (w_cw.pc_we & (~w_cw.ready_gate | bus.mem_ready)) |
                        (w_cw.pc_br & bus.zero);
  assign bus.mem_req  = w_cw.mem_req;
  assign bus.mem_we   = w_cw.mem_we & w_cw.mem_req;
  assign bus.iord     = w_cw.iord;
  assign bus.pc_src   = w_cw.pc_src;
  assign bus.alu_srca = w_cw.alu_srca;
  assign bus.alu_srcb = w_cw.alu_srcb;
  assign bus.alu_op   = w_cw.alu_op;
  assign bus.reg_dst  = w_cw.reg_dst;
  assign bus.mem2reg  = w_cw.mem2reg;
  assign bus.reg_we   = w_cw.reg_we;
  assign bus.illegal  = w_illegal;
  assign bus.state_o  = STW'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm : directed self-checking bench for mc_ctrl_fsm
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  localparam int ST_RST = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3,
                 ST_MEMRD = 4, ST_MEMWB = 5, ST_MEMWR = 6, ST_RTEXE = 7,
                 ST_ALUWB = 8, ST_BEQ = 9, ST_JUMP = 10, ST_ADDIEX = 11,
                 ST_ADDIWB = 12;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  mc_ctrl_fsm_if #(.OPW(6), .STW(4)) bus ();

  mc_ctrl_fsm #(.OPW(6), .STW(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] w_obs;
  assign w_obs = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_we, bus.pc_en,
                  bus.pc_src, bus.alu_srca, bus.alu_srcb, bus.alu_op,
                  bus.reg_dst, bus.mem2reg, bus.reg_we, bus.illegal, bus.state_o};

  // Expected output vector, written straight from the state table
  function automatic logic [19:0] expw(input int st, input logic rdy,
                                       input logic z, input logic ill);
    logic       mreq, mwe, iord, irwe, pcen, srca, rdst, m2r, rwe;
    logic [1:0] psrc, srcb, aop;
    mreq = 0; mwe = 0; iord = 0; irwe = 0; pcen = 0; srca = 0;
    rdst = 0; m2r = 0; rwe = 0; psrc = 0; srcb = 0; aop = 0;
    case (st)
      ST_FETCH:  begin mreq = 1; srcb = 2'b01; irwe = rdy; pcen = rdy; end
      ST_DECODE: srcb = 2'b11;
      ST_MEMADR: begin srca = 1; srcb = 2'b10; end
      ST_MEMRD:  begin mreq = 1; iord = 1; end
      ST_MEMWB:  begin rwe = 1; m2r = 1; end
      ST_MEMWR:  begin mreq = 1; mwe = 1; iord = 1; end
      ST_RTEXE:  begin srca = 1; aop = 2'b10; end
      ST_ALUWB:  begin rwe = 1; rdst = 1; end
      ST_BEQ:    begin srca = 1; aop = 2'b01; psrc = 2'b01; pcen = z; end
      ST_JUMP:   begin psrc = 2'b10; pcen = 1; end
      ST_ADDIEX: begin srca = 1; srcb = 2'b10; end
      ST_ADDIWB: rwe = 1;
      default:   ;
    endcase
    return {mreq, mwe, iord, irwe, pcen, psrc, srca, srcb, aop,
            rdst, m2r, rwe, ill, 4'(st)};
  endfunction

  task automatic chk(input string tag, input int st, input logic ill = 1'b0);
    logic [19:0] exp_v;
    #1;
    exp_v = expw(st, bus.mem_ready, bus.zero, ill);
    checks++;
    assert (w_obs === exp_v)
      else begin
        errors++;
        $error("FAIL %s: observed %05h expected %05h", tag, w_obs, exp_v);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    bus.opcode = 6'b100011;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", ST_RST);
    rstn = 1'b1;
    chk("reset_released", ST_RST);

    // lw, memory always ready: 5 cycles
    step(); chk("lw_fetch", ST_FETCH);
    step(); chk("lw_decode", ST_DECODE);
    step(); chk("lw_memadr", ST_MEMADR);
    step(); chk("lw_memrd", ST_MEMRD);
    step(); chk("lw_memwb", ST_MEMWB);

    // sw with three stall cycles in MEMWR
    step(); bus.opcode = 6'b101011; chk("sw_fetch", ST_FETCH);
    step(); chk("sw_decode", ST_DECODE);
    step(); bus.mem_ready = 1'b0; chk("sw_memadr", ST_MEMADR);
    step(); chk("sw_memwr_stall1", ST_MEMWR);
    step(); chk("sw_memwr_stall2", ST_MEMWR);
    step(); chk("sw_memwr_stall3", ST_MEMWR);
    step(); bus.mem_ready = 1'b1; chk("sw_memwr_done", ST_MEMWR);

    // FETCH stalls when memory is not ready
    step(); bus.mem_ready = 1'b0; bus.opcode = 6'b000100; chk("fetch_stall", ST_FETCH);
    step(); bus.mem_ready = 1'b1; chk("fetch_after_stall", ST_FETCH);

    // beq taken
    step(); chk("beq_t_decode", ST_DECODE);
    step(); bus.zero = 1'b1; chk("beq_taken", ST_BEQ);
    step(); bus.zero = 1'b0; chk("beq_t_fetch", ST_FETCH);
    // beq not taken
    step(); chk("beq_n_decode", ST_DECODE);
    step(); chk("beq_not_taken", ST_BEQ);

    // R-type; opcode change in RTEXE must be ignored
    step(); bus.opcode = 6'b000000; chk("r_fetch", ST_FETCH);
    step(); chk("r_decode", ST_DECODE);
    step(); bus.opcode = 6'b111111; chk("r_exe", ST_RTEXE);
    step(); chk("r_aluwb", ST_ALUWB);

    // addi
    step(); bus.opcode = 6'b001000; chk("addi_fetch", ST_FETCH);
    step(); chk("addi_decode", ST_DECODE);
    step(); chk("addi_ex", ST_ADDIEX);
    step(); chk("addi_wb", ST_ADDIWB);

    // jump
    step(); bus.opcode = 6'b000010; chk("j_fetch", ST_FETCH);
    step(); chk("j_decode", ST_DECODE);
    step(); chk("j_jump", ST_JUMP);

    // illegal opcode
    step(); bus.opcode = 6'b111111; chk("ill_fetch", ST_FETCH);
    step(); chk("ill_decode", ST_DECODE, 1'b1);
    step(); chk("ill_back_fetch", ST_FETCH);

    // reset asserted mid-MEMRD
    bus.opcode = 6'b100011;
    step(); chk("rst_decode", ST_DECODE);
    step(); bus.mem_ready = 1'b0; chk("rst_memadr", ST_MEMADR);
    step(); chk("rst_memrd", ST_MEMRD);
    #1; rstn = 1'b0;
    chk("rst_async", ST_RST);
    #1; rstn = 1'b1; bus.mem_ready = 1'b1;
    step(); chk("rst_refetch", ST_FETCH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
